banana_launch_scheduler: RTL and testbench

//   Sequences a pool of NUM_SLOTS banana projectile movers. Accepts launch requests and picks a free slot round-robin.

---
 rtl/banana_launch_scheduler.sv | 199 +++++++++++++++++++
 tb/tb_banana_launch_scheduler.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/banana_launch_scheduler.sv
// Round-robin launcher for a pool of banana movers, with a frame-based cooldown and an ack timeout.
// Optional: define BANANA_SCHED_STATS_EN to add saturating launch_count / abort_count outputs.
module banana_launch_scheduler #(
    parameter int unsigned NUM_SLOTS       = 4,
    parameter int unsigned COOLDOWN_FRAMES = 15,
    parameter int          Y_MIN           = 16,
    parameter int          Y_MAX           = 400,
    parameter int unsigned ACK_TIMEOUT     = 2
) (
    input  logic                 clk,
    input  logic                 resetN,
    input  logic                 startOfFrame,
    input  logic                 launch_req,
    input  logic [10:0]          launch_y,
    input  logic [NUM_SLOTS-1:0] slot_active,
    input  logic [NUM_SLOTS-1:0] slot_retire,
    output logic                 launch_ack,
    output logic                 launch_abort,
    output logic [NUM_SLOTS-1:0] appear,
    output logic [10:0]          initial_y,
    output logic [NUM_SLOTS-1:0] slot_kill,
`ifdef BANANA_SCHED_STATS_EN
    output logic [15:0]          launch_count,
    output logic [7:0]           abort_count,
`endif
    output logic [NUM_SLOTS-1:0] slot_busy
);

    localparam int unsigned SLOT_W = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
    localparam int unsigned CD_W   = $clog2(COOLDOWN_FRAMES + 2);
    localparam int unsigned TO_W   = $clog2(ACK_TIMEOUT + 2);
    localparam int unsigned Y_W    = 11;
    localparam logic signed [Y_W-1:0] Y_LO = Y_W'(Y_MIN);
    localparam logic signed [Y_W-1:0] Y_HI = Y_W'(Y_MAX);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_GRANT    = 2'd1,
        S_WAIT_ACT = 2'd2,
        S_COOLDOWN = 2'd3
    } state_t;

    state_t                r_state, w_state_nxt;
    logic [SLOT_W-1:0]     r_rr, w_rr_nxt;
    logic [SLOT_W-1:0]     r_sel, w_sel_nxt;
    logic [CD_W-1:0]       r_cd, w_cd_nxt;
    logic [TO_W-1:0]       r_frm, w_frm_nxt;
    logic [NUM_SLOTS-1:0]  r_appear, w_appear_nxt;
    logic [NUM_SLOTS-1:0]  r_busy, w_busy_nxt;
    logic [NUM_SLOTS-1:0]  r_kill, w_kill_nxt;
    logic                  r_ack, w_ack_nxt;
    logic                  r_abort, w_abort_nxt;
    logic [Y_W-1:0]        r_init_y, w_init_y_nxt;
    logic [NUM_SLOTS-1:0]  w_retire;
    logic [SLOT_W:0]       w_pick;
    logic [NUM_SLOTS-1:0]  w_onehot;

    // First free slot at or after rr, wrapping; MSB flags that one was found.
    function automatic logic [SLOT_W:0] pick_free(input logic [NUM_SLOTS-1:0] busy,
                                                  input logic [SLOT_W-1:0]    rr);
        logic [SLOT_W:0] res;
        int unsigned     idx;
        res = '0;
        for (int unsigned k = 0; k < NUM_SLOTS; k++) begin
            idx = 32'(rr) + k;
            if (idx >= NUM_SLOTS) idx = idx - NUM_SLOTS;
            if (!res[SLOT_W] && !busy[SLOT_W'(idx)]) res = {1'b1, SLOT_W'(idx)};
        end
        return res;
    endfunction

    function automatic logic [Y_W-1:0] clamp_y(input logic [Y_W-1:0] y);
        if ($signed(y) < Y_LO) return Y_LO;
        if ($signed(y) > Y_HI) return Y_HI;
        return y;
    endfunction

    // Retires only count for occupied slots; the pick uses pre-retire occupancy.
    assign w_retire = slot_retire & r_busy;
    assign w_pick   = pick_free(r_busy, r_rr);
    assign w_onehot = NUM_SLOTS'(1) << w_pick[SLOT_W-1:0];

    always_comb begin
        w_state_nxt  = r_state;
        w_rr_nxt     = r_rr;
        w_sel_nxt    = r_sel;
        w_cd_nxt     = r_cd;
        w_frm_nxt    = r_frm;
        w_appear_nxt = r_appear;
        w_busy_nxt   = r_busy & ~w_retire;
        w_kill_nxt   = w_retire;
        w_ack_nxt    = 1'b0;
        w_abort_nxt  = 1'b0;
        w_init_y_nxt = r_init_y;

        case (r_state)
            S_IDLE: begin
                if (launch_req && (r_cd == '0) && !(&r_busy)) w_state_nxt = S_GRANT;
            end
            S_GRANT: begin
                if (w_pick[SLOT_W]) begin
                    w_sel_nxt    = w_pick[SLOT_W-1:0];
                    w_appear_nxt = w_onehot;
                    w_busy_nxt   = w_busy_nxt | w_onehot;
                    w_rr_nxt     = (w_pick[SLOT_W-1:0] == SLOT_W'(NUM_SLOTS - 1)) ?
                                   '0 : w_pick[SLOT_W-1:0] + SLOT_W'(1);
                    w_init_y_nxt = clamp_y(launch_y);
                    w_frm_nxt    = '0;
                    w_state_nxt  = S_WAIT_ACT;
                end else begin
                    w_state_nxt  = S_IDLE;
                end
            end
            S_WAIT_ACT: begin
                if (w_retire[r_sel]) begin
                    w_appear_nxt = '0;
                    w_cd_nxt     = '0;
                    w_state_nxt  = S_IDLE;
                end else if (slot_active[r_sel]) begin
                    w_appear_nxt = '0;
                    w_ack_nxt    = 1'b1;
                    w_cd_nxt     = CD_W'(COOLDOWN_FRAMES);
                    w_state_nxt  = S_COOLDOWN;
                end else if (startOfFrame) begin
                    if (32'(r_frm) + 32'd1 >= ACK_TIMEOUT) begin
                        w_appear_nxt       = '0;
                        w_busy_nxt[r_sel]  = 1'b0;
                        w_kill_nxt[r_sel]  = 1'b1;
                        w_abort_nxt        = 1'b1;
                        w_cd_nxt           = '0;
                        w_state_nxt        = S_IDLE;
                    end else begin
                        w_frm_nxt = r_frm + TO_W'(1);
                    end
                end
            end
            S_COOLDOWN: begin
                if (r_cd == '0)        w_state_nxt = S_IDLE;
                else if (startOfFrame) w_cd_nxt    = r_cd - CD_W'(1);
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_state  <= S_IDLE;
            r_rr     <= '0;
            r_sel    <= '0;
            r_cd     <= '0;
            r_frm    <= '0;
            r_appear <= '0;
            r_busy   <= '0;
            r_kill   <= '0;
            r_ack    <= 1'b0;
            r_abort  <= 1'b0;
            r_init_y <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_rr     <= w_rr_nxt;
            r_sel    <= w_sel_nxt;
            r_cd     <= w_cd_nxt;
            r_frm    <= w_frm_nxt;
            r_appear <= w_appear_nxt;
            r_busy   <= w_busy_nxt;
            r_kill   <= w_kill_nxt;
            r_ack    <= w_ack_nxt;
            r_abort  <= w_abort_nxt;
            r_init_y <= w_init_y_nxt;
        end
    end

    assign launch_ack   = r_ack;
    assign launch_abort = r_abort;
    assign appear       = r_appear;
    assign initial_y    = r_init_y;
    assign slot_kill    = r_kill;
    assign slot_busy    = r_busy;

`ifdef BANANA_SCHED_STATS_EN
    logic [15:0] r_launch_cnt;
    logic [7:0]  r_abort_cnt;

    // Saturating event counters, updated alongside the ack/abort pulses.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_launch_cnt <= '0;
            r_abort_cnt  <= '0;
        end else begin
            if (w_ack_nxt && (r_launch_cnt != '1))  r_launch_cnt <= r_launch_cnt + 16'd1;
            if (w_abort_nxt && (r_abort_cnt != '1)) r_abort_cnt  <= r_abort_cnt + 8'd1;
        end
    end

    assign launch_count = r_launch_cnt;
    assign abort_count  = r_abort_cnt;
`endif

endmodule

// File: tb/tb_banana_launch_scheduler.sv
// Directed bench for banana_launch_scheduler: default build plus a zero-cooldown instance.
`timescale 1ns/1ps
module tb_banana_launch_scheduler;

    logic        clk = 1'b0;
    logic        resetN;
    logic        sof;
    logic [10:0] launch_y;
    logic        req, req0;
    logic [3:0]  act, act0, ret, ret0;
    logic        ack, abort, ack0, abort0;
    logic [3:0]  appear, kill, busy, appear0, kill0, busy0;
    logic [10:0] iy, iy0;
`ifdef BANANA_SCHED_STATS_EN
    logic [15:0] lcnt, lcnt0;
    logic [7:0]  acnt, acnt0;
`endif

    int total   = 0;
    int bad     = 0;
    int sof_cnt = 0;

    always #5 clk = ~clk;

    banana_launch_scheduler dut (
        .clk(clk), .resetN(resetN), .startOfFrame(sof), .launch_req(req), .launch_y(launch_y),
        .slot_active(act), .slot_retire(ret), .launch_ack(ack), .launch_abort(abort),
        .appear(appear), .initial_y(iy), .slot_kill(kill),
`ifdef BANANA_SCHED_STATS_EN
        .launch_count(lcnt), .abort_count(acnt),
`endif
        .slot_busy(busy)
    );

    banana_launch_scheduler #(.COOLDOWN_FRAMES(0)) dut0 (
        .clk(clk), .resetN(resetN), .startOfFrame(sof), .launch_req(req0), .launch_y(launch_y),
        .slot_active(act0), .slot_retire(ret0), .launch_ack(ack0), .launch_abort(abort0),
        .appear(appear0), .initial_y(iy0), .slot_kill(kill0),
`ifdef BANANA_SCHED_STATS_EN
        .launch_count(lcnt0), .abort_count(acnt0),
`endif
        .slot_busy(busy0)
    );

    // One frame pulse every 5 cycles.
    initial begin
        sof = 1'b0;
        forever begin
            repeat (4) @(negedge clk);
            sof = 1'b1;
            @(negedge clk);
            sof = 1'b0;
        end
    end

    always @(posedge clk) if (sof) sof_cnt <= sof_cnt + 1;

    task automatic wait_appear(input bit use0, input int limit, output int cyc);
        cyc = -1;
        for (int i = 1; i <= limit; i++) begin
            @(negedge clk);
            if ((use0 ? appear0 : appear) != 4'b0) begin
                cyc = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        resetN = 1'b0; req = 1'b0; req0 = 1'b0; launch_y = 11'd0;
        act = '0; act0 = '0; ret = '0; ret0 = '0;
        repeat (3) @(negedge clk);
        total++;
        if ({ack, abort, appear, iy, kill, busy} !== 25'd0) begin
            bad++; $display("FAIL reset_outputs: got %h want 0", {ack, abort, appear, iy, kill, busy});
        end
        total++;
        if ({ack0, abort0, appear0, iy0, kill0, busy0} !== 25'd0) begin
            bad++; $display("FAIL reset_outputs0: got %h want 0", {ack0, abort0, appear0, iy0, kill0, busy0});
        end
        resetN = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_launch_seq();
        int cyc;
        int t_ack = 0;
        req = 1'b1; launch_y = 11'd100;
        for (int k = 0; k < 4; k++) begin
            wait_appear(1'b0, 200, cyc);
            total++;
            if (appear !== 4'(1 << k)) begin
                bad++; $display("FAIL grant_slot k=%0d: got %b want %b", k, appear, 4'(1 << k));
            end
            total++;
            if (k == 0 && cyc !== 2) begin
                bad++; $display("FAIL first_grant_latency: got %0d want 2", cyc);
            end else if (k != 0 && (sof_cnt - t_ack) !== 15) begin
                bad++; $display("FAIL cooldown_frames k=%0d: got %0d want 15", k, sof_cnt - t_ack);
            end
            total++;
            if (iy !== 11'd100 || busy[k] !== 1'b1) begin
                bad++; $display("FAIL grant_y_busy k=%0d: got y=%0d busy=%b want y=100 bit set", k, iy, busy);
            end
            repeat (2) @(negedge clk);
            act[k] = 1'b1;
            @(negedge clk);
            total++;
            if (ack !== 1'b1 || appear !== 4'b0) begin
                bad++; $display("FAIL ack k=%0d: got ack=%b appear=%b want 1/0000", k, ack, appear);
            end
            t_ack = sof_cnt;
        end
        total++;
        if (busy !== 4'hF) begin bad++; $display("FAIL busy_full: got %b want 1111", busy); end
    endtask

    task automatic test_full_retire();
        int cyc;
        bit seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (appear !== 4'b0) seen = 1'b1;
        end
        total++;
        if (seen || busy !== 4'hF) begin
            bad++; $display("FAIL no_grant_when_full: got seen=%b busy=%b want 0/1111", seen, busy);
        end
        ret = 4'b0100; act[2] = 1'b0;
        @(negedge clk);
        ret = '0;
        total++;
        if (kill !== 4'b0100 || busy !== 4'b1011) begin
            bad++; $display("FAIL retire_kill: got kill=%b busy=%b want 0100/1011", kill, busy);
        end
        wait_appear(1'b0, 200, cyc);
        total++;
        if (appear !== 4'b0100) begin bad++; $display("FAIL regrant_slot2: got %b want 0100", appear); end
        repeat (2) @(negedge clk);
        act[2] = 1'b1;
        @(negedge clk);
        total++;
        if (ack !== 1'b1) begin bad++; $display("FAIL regrant_ack: got %b want 1", ack); end
    endtask

    task automatic test_clamp();
        int cyc;
        logic [10:0] ys [2];
        logic [10:0] want [2];
        ys[0] = 11'h7FB; want[0] = 11'd16;
        ys[1] = 11'd600; want[1] = 11'd400;
        for (int n = 0; n < 2; n++) begin
            launch_y = ys[n];
            ret = 4'b0001; act[0] = 1'b0;
            @(negedge clk);
            ret = '0;
            total++;
            if (kill !== 4'b0001) begin bad++; $display("FAIL clamp_kill n=%0d: got %b want 0001", n, kill); end
            wait_appear(1'b0, 200, cyc);
            total++;
            if (appear !== 4'b0001 || iy !== want[n]) begin
                bad++; $display("FAIL clamp n=%0d: got appear=%b y=%0d want 0001/%0d", n, appear, iy, want[n]);
            end
            repeat (2) @(negedge clk);
            act[0] = 1'b1;
            @(negedge clk);
            total++;
            if (ack !== 1'b1) begin bad++; $display("FAIL clamp_ack n=%0d: got %b want 1", n, ack); end
        end
    endtask

    task automatic test_timeout();
        int cyc;
        int t0;
        ret = 4'b0010; act[1] = 1'b0;
        @(negedge clk);
        ret = '0;
        total++;
        if (kill !== 4'b0010 || busy !== 4'b1101) begin
            bad++; $display("FAIL retire1: got kill=%b busy=%b want 0010/1101", kill, busy);
        end
        @(negedge clk);
        ret = 4'b0010;
        @(negedge clk);
        ret = '0;
        total++;
        if (kill !== 4'b0000) begin bad++; $display("FAIL retire_idle_slot: got %b want 0000", kill); end
        wait_appear(1'b0, 200, cyc);
        t0 = sof_cnt;
        total++;
        if (appear !== 4'b0010) begin bad++; $display("FAIL timeout_grant: got %b want 0010", appear); end
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (abort) break;
        end
        req = 1'b0;
        total++;
        if (abort !== 1'b1 || kill !== 4'b0010 || busy !== 4'b1101 || appear !== 4'b0) begin
            bad++; $display("FAIL abort: got abort=%b kill=%b busy=%b appear=%b want 1/0010/1101/0000",
                            abort, kill, busy, appear);
        end
        total++;
        if ((sof_cnt - t0) !== 2) begin bad++; $display("FAIL abort_frames: got %0d want 2", sof_cnt - t0); end
`ifdef BANANA_SCHED_STATS_EN
        total++;
        if (acnt !== 8'd1 || lcnt !== 16'd7) begin
            bad++; $display("FAIL stats_abort: got l=%0d a=%0d want 7/1", lcnt, acnt);
        end
`endif
        @(negedge clk);
        total++;
        if (abort !== 1'b0 || kill !== 4'b0) begin
            bad++; $display("FAIL abort_pulse: got abort=%b kill=%b want 0/0000", abort, kill);
        end
        repeat (5) @(negedge clk);
        total++;
        if (appear !== 4'b0) begin bad++; $display("FAIL no_req_no_grant: got %b want 0000", appear); end
    endtask

    task automatic test_retire_wait();
        int cyc;
        req = 1'b1;
        wait_appear(1'b0, 50, cyc);
        total++;
        if (appear !== 4'b0010) begin bad++; $display("FAIL retire_wait_grant: got %b want 0010", appear); end
        ret = 4'b0010;
        @(negedge clk);
        ret = '0; req = 1'b0;
        total++;
        if (kill !== 4'b0010 || abort !== 1'b0 || appear !== 4'b0 || busy !== 4'b1101) begin
            bad++; $display("FAIL retire_in_wait: got kill=%b abort=%b appear=%b busy=%b want 0010/0/0000/1101",
                            kill, abort, appear, busy);
        end
    endtask

    task automatic test_reset_midwait();
        int cyc;
        req = 1'b1;
        wait_appear(1'b0, 50, cyc);
        total++;
        if (appear !== 4'b0010) begin bad++; $display("FAIL midwait_grant: got %b want 0010", appear); end
        #2 resetN = 1'b0;
        #1;
        total++;
        if (appear !== 4'b0 || busy !== 4'b0) begin
            bad++; $display("FAIL async_reset: got appear=%b busy=%b want 0000/0000", appear, busy);
        end
        @(negedge clk);
        resetN = 1'b1; act = '0;
        wait_appear(1'b0, 50, cyc);
        total++;
        if (appear !== 4'b0001) begin bad++; $display("FAIL post_reset_slot0: got %b want 0001", appear); end
        repeat (2) @(negedge clk);
        act[0] = 1'b1;
        @(negedge clk);
        req = 1'b0;
        total++;
        if (ack !== 1'b1) begin bad++; $display("FAIL post_reset_ack: got %b want 1", ack); end
`ifdef BANANA_SCHED_STATS_EN
        total++;
        if (lcnt !== 16'd1 || acnt !== 8'd0) begin
            bad++; $display("FAIL stats_reset: got l=%0d a=%0d want 1/0", lcnt, acnt);
        end
`endif
    endtask

    task automatic test_back_to_back();
        int cyc;
        req0 = 1'b1;
        for (int k = 0; k < 4; k++) begin
            wait_appear(1'b1, 50, cyc);
            total++;
            if (appear0 !== 4'(1 << k)) begin
                bad++; $display("FAIL b2b_slot k=%0d: got %b want %b", k, appear0, 4'(1 << k));
            end
            if (k != 0) begin
                total++;
                if (cyc !== 3) begin bad++; $display("FAIL b2b_gap k=%0d: got %0d want 3", k, cyc); end
            end
            repeat (2) @(negedge clk);
            act0[k] = 1'b1;
            @(negedge clk);
            total++;
            if (ack0 !== 1'b1) begin bad++; $display("FAIL b2b_ack k=%0d: got %b want 1", k, ack0); end
        end
        ret0 = 4'b0101; act0[0] = 1'b0; act0[2] = 1'b0;
        @(negedge clk);
        ret0 = '0;
        total++;
        if (kill0 !== 4'b0101) begin bad++; $display("FAIL b2b_kill: got %b want 0101", kill0); end
        wait_appear(1'b1, 50, cyc);
        req0 = 1'b0;
        total++;
        if (appear0 !== 4'b0001) begin bad++; $display("FAIL rr_wrap: got %b want 0001", appear0); end
    endtask

    initial begin
        test_reset();
        test_launch_seq();
        test_full_retire();
        test_clamp();
        test_timeout();
        test_retire_wait();
        test_reset_midwait();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
